// File: rtl/canny_frame_uart_tx.sv
// Binarises Canny pixels, packs them 8 per byte into a frame RAM and streams the frame
// as an 8N1 UART packet (HDR0, HDR1, payload). Define CANNY_TX_CKSUM_EN to append an XOR checksum byte.
module canny_frame_uart_tx #(
  parameter int         IMG_W    = 170,
  parameter int         IMG_H    = 240,
  parameter logic [7:0] THRESH   = 8'd128,
  parameter int         CLK_FREQ = 100_000_000,
  parameter int         BAUD     = 115200,
  parameter logic [7:0] HDR0     = 8'hA5,
  parameter logic [7:0] HDR1     = 8'h5A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       canny_de,
  input  logic [7:0] canny_r,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_drop
);

  localparam int NPIX    = IMG_W * IMG_H;
  localparam int NBYTES  = NPIX / 8;
  localparam int AW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int PCW     = $clog2(NPIX + 1);
  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int BCW     = $clog2(BIT_DIV);

  localparam logic [PCW-1:0] LAST_PIX  = PCW'(NPIX - 1);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(NBYTES - 1);
  localparam logic [BCW-1:0] BAUD_TOP  = BCW'(BIT_DIV - 1);

  typedef enum logic [2:0] {
    S_CAPTURE,
    S_HDR0,
    S_HDR1,
    S_PAYLOAD,
`ifdef CANNY_TX_CKSUM_EN
    S_CKSUM,
`endif
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PCW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [7:0]       pack_q, pack_d;
  logic             armed_q, armed_d;
  logic             frame_drop_q, frame_drop_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [7:0]       rd_data_q;
  logic             ser_busy_q, ser_busy_d;
  logic             tx_q, tx_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]   baud_cnt_q, baud_cnt_d;
`ifdef CANNY_TX_CKSUM_EN
  logic [7:0]       cksum_q, cksum_d;
`endif

  logic [PCW-1:0]   base_cnt;
  logic [7:0]       base_pack;
  logic [7:0]       packed_byte;
  logic             accept;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             last_pix;
  logic             ser_load;
  logic [7:0]       ser_byte;

  // A frame_start coinciding with a valid pixel makes that pixel pixel 0 of the new frame.
  always_comb begin
    base_cnt     = frame_start ? '0 : pix_cnt_q;
    base_pack    = frame_start ? '0 : pack_q;
    packed_byte  = {base_pack[6:0], (canny_r >= THRESH)};
    accept       = (state_q == S_CAPTURE) && canny_de && (armed_q || frame_start);
    wr_en        = accept && (base_cnt[2:0] == 3'd7);
    wr_addr      = AW'(base_cnt >> 3);
    last_pix     = accept && (base_cnt == LAST_PIX);
    pix_cnt_d    = pix_cnt_q;
    pack_d       = pack_q;
    armed_d      = armed_q;
    frame_drop_d = canny_de && (state_q != S_CAPTURE);
    if ((state_q == S_CAPTURE) && frame_start) begin
      armed_d   = 1'b1;
      pix_cnt_d = '0;
      pack_d    = '0;
    end
    if (accept) begin
      pix_cnt_d = base_cnt + PCW'(1);
      pack_d    = packed_byte;
    end
    if (last_pix) begin
      pix_cnt_d = '0;
      pack_d    = '0;
      armed_d   = 1'b0;
    end
  end

  logic [7:0] ram [NBYTES];

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= packed_byte;
    rd_data_q <= ram[addr_q];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_CAPTURE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CAPTURE: if (last_pix)    state_d = S_HDR0;
      S_HDR0:    if (!ser_busy_q) state_d = S_HDR1;
      S_HDR1:    if (!ser_busy_q) state_d = S_PAYLOAD;
      S_PAYLOAD: if (!ser_busy_q && (addr_q == LAST_ADDR)) begin
`ifdef CANNY_TX_CKSUM_EN
        state_d = S_CKSUM;
`else
        state_d = S_DONE;
`endif
      end
`ifdef CANNY_TX_CKSUM_EN
      S_CKSUM:   if (!ser_busy_q) state_d = S_DONE;
`endif
      S_DONE:    if (!ser_busy_q) state_d = S_CAPTURE;
      default:   state_d = S_CAPTURE;
    endcase
  end

  always_comb begin
    ser_load   = 1'b0;
    ser_byte   = HDR0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_HDR0: begin
        busy     = 1'b1;
        ser_load = !ser_busy_q;
        ser_byte = HDR0;
      end
      S_HDR1: begin
        busy     = 1'b1;
        ser_load = !ser_busy_q;
        ser_byte = HDR1;
      end
      S_PAYLOAD: begin
        busy     = 1'b1;
        ser_load = !ser_busy_q;
        ser_byte = rd_data_q;
      end
`ifdef CANNY_TX_CKSUM_EN
      S_CKSUM: begin
        busy     = 1'b1;
        ser_load = !ser_busy_q;
        ser_byte = cksum_q;
      end
`endif
      S_DONE: begin
        busy       = ser_busy_q;
        frame_done = !ser_busy_q;
      end
      default: ;
    endcase
  end

  // The read address is parked at the next byte so its data is ready by the following load.
  always_comb begin
    addr_d = addr_q;
    if (state_q == S_CAPTURE)
      addr_d = '0;
    else if ((state_q == S_PAYLOAD) && ser_load && (addr_q != LAST_ADDR))
      addr_d = addr_q + AW'(1);
  end

`ifdef CANNY_TX_CKSUM_EN
  always_comb begin
    cksum_d = cksum_q;
    if (state_q == S_CAPTURE)
      cksum_d = '0;
    else if ((state_q == S_PAYLOAD) && ser_load)
      cksum_d = cksum_q ^ rd_data_q;
  end
`endif

  // Serializer: shift_q holds data LSB-first followed by the stop bit.
  always_comb begin
    ser_busy_d = ser_busy_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    if (ser_load) begin
      ser_busy_d = 1'b1;
      tx_d       = 1'b0;
      shift_d    = {1'b1, ser_byte};
      bit_cnt_d  = '0;
      baud_cnt_d = '0;
    end else if (ser_busy_q) begin
      if (baud_cnt_q == BAUD_TOP) begin
        baud_cnt_d = '0;
        if (bit_cnt_q == 4'd9) begin
          ser_busy_d = 1'b0;
          bit_cnt_d  = '0;
        end else begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end else begin
        baud_cnt_d = baud_cnt_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt_q    <= '0;
      pack_q       <= '0;
      armed_q      <= 1'b0;
      frame_drop_q <= 1'b0;
      addr_q       <= '0;
      ser_busy_q   <= 1'b0;
      tx_q         <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      baud_cnt_q   <= '0;
`ifdef CANNY_TX_CKSUM_EN
      cksum_q      <= '0;
`endif
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      pack_q       <= pack_d;
      armed_q      <= armed_d;
      frame_drop_q <= frame_drop_d;
      addr_q       <= addr_d;
      ser_busy_q   <= ser_busy_d;
      tx_q         <= tx_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      baud_cnt_q   <= baud_cnt_d;
`ifdef CANNY_TX_CKSUM_EN
      cksum_q      <= cksum_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_canny_frame_uart_tx.sv
// Directed bench for canny_frame_uart_tx on an 8x2 frame with 4 clocks per UART bit.
module tb_canny_frame_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_start = 1'b0;
  logic       canny_de = 1'b0;
  logic [7:0] canny_r = 8'd0;
  logic       tx, busy, frame_done, frame_drop;

  canny_frame_uart_tx #(
    .IMG_W(8), .IMG_H(2), .THRESH(8'd128), .CLK_FREQ(400), .BAUD(100),
    .HDR0(8'hA5), .HDR1(8'h5A)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .canny_de(canny_de),
    .canny_r(canny_r), .tx(tx), .busy(busy), .frame_done(frame_done), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART receiver: sample each bit near its centre, 4 clocks per bit
  logic [7:0] rx_q[$];
  int         start_q[$];
  logic [7:0] mon_byte;
  always begin
    @(negedge clk);
    if (reset && tx === 1'b0) begin
      start_q.push_back(cyc);
      repeat (6) @(negedge clk);
      mon_byte[0] = tx;
      for (int i = 1; i < 8; i++) begin
        repeat (4) @(negedge clk);
        mon_byte[i] = tx;
      end
      repeat (4) @(negedge clk);
      check_val("stop_bit", {31'd0, tx}, 32'd1);
      rx_q.push_back(mon_byte);
    end
  end

  int done_cnt = 0;
  int drop_cnt = 0;
  int done_cyc = 0;
  always @(negedge clk) begin
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (frame_drop) drop_cnt <= drop_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] v);
    canny_de = 1'b1;
    canny_r  = v;
    @(posedge clk);
    #1;
    canny_de = 1'b0;
    canny_r  = 8'd0;
  endtask

  task automatic fstart();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  // Pixels first..last of a 16-pixel frame; pixel i is bits[15-i] (first pixel -> byte0 bit7)
  task automatic send_pix(input logic [15:0] bits, input logic [7:0] hi, input logic [7:0] lo,
                          input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      pix(bits[15-i] ? hi : lo);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    start_q.delete();
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 2000 && done_cnt == d0; i++) @(posedge clk);
    idle(6);
    check_val({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
    check_val({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_pkt(input string tag, input logic [7:0] p0, input logic [7:0] p1);
    logic [7:0] exp[$];
    exp = '{8'hA5, 8'h5A, p0, p1};
`ifdef CANNY_TX_CKSUM_EN
    exp.push_back(p0 ^ p1);
`endif
    check_val({tag, "_len"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < rx_q.size())
        check_val($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int d0;
  int lat;

  initial begin
    idle(3);
    check_val("rst_tx", {31'd0, tx}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, frame_done}, 32'd0);
    check_val("rst_drop", {31'd0, frame_drop}, 32'd0);
    reset = 1'b1;
    idle(2);

    // 1: alternating 200/0 -> AA AA, latency bound
    clear_rx();
    fstart();
    send_pix(16'hAAAA, 8'd200, 8'd0, 0, 14, 0);
    idle(3);
    check_val("s1_busy_pre", {31'd0, busy}, 32'd0);
    send_pix(16'hAAAA, 8'd200, 8'd0, 15, 15, 0);
    check_val("s1_busy_post", {31'd0, busy}, 32'd1);
    wait_done("s1");
    check_pkt("s1", 8'hAA, 8'hAA);
    lat = (start_q.size() > 0) ? done_cyc - start_q[0] : 0;
`ifdef CANNY_TX_CKSUM_EN
    check_val("s1_latency_ok", {31'd0, (lat >= 200 && lat <= 204)}, 32'd1);
`else
    check_val("s1_latency_ok", {31'd0, (lat >= 160 && lat <= 163)}, 32'd1);
`endif
    $display("s1 packet latency %0d clocks", lat);

    // 2: threshold boundary 127/128 -> 55 55
    clear_rx();
    fstart();
    send_pix(16'h5555, 8'd128, 8'd127, 0, 15, 0);
    wait_done("s2");
    check_pkt("s2", 8'h55, 8'h55);

    // 3: de every 3rd cycle -> AA AA
    clear_rx();
    fstart();
    send_pix(16'hAAAA, 8'd200, 8'd0, 0, 14, 2);
    check_val("s3_busy_pre", {31'd0, busy}, 32'd0);
    send_pix(16'hAAAA, 8'd200, 8'd0, 15, 15, 0);
    check_val("s3_busy_post", {31'd0, busy}, 32'd1);
    wait_done("s3");
    check_pkt("s3", 8'hAA, 8'hAA);

    // 4: pixels while busy are dropped; no restart without frame_start
    clear_rx();
    fstart();
    send_pix(16'hAAAA, 8'd200, 8'd0, 0, 15, 0);
    idle(5);
    d0 = drop_cnt;
    for (int i = 0; i < 5; i++) begin
      pix(8'd200);
      idle(2);
    end
    wait_done("s4");
    check_val("s4_drops", drop_cnt - d0, 32'd5);
    check_pkt("s4", 8'hAA, 8'hAA);
    clear_rx();
    send_pix(16'hFFFF, 8'd200, 8'd0, 0, 15, 0);
    idle(60);
    check_val("s4_no_restart_busy", {31'd0, busy}, 32'd0);
    check_val("s4_no_restart_rx", rx_q.size(), 32'd0);
    fstart();
    send_pix(16'hF00F, 8'd200, 8'd0, 0, 15, 0);
    wait_done("s4b");
    check_pkt("s4b", 8'hF0, 8'h0F);

    // 5: partial frame discarded; frame_start with de makes pixel 0
    clear_rx();
    fstart();
    send_pix(16'h0000, 8'd200, 8'd0, 0, 4, 0);
    frame_start = 1'b1;
    canny_de    = 1'b1;
    canny_r     = 8'd255;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    canny_de    = 1'b0;
    send_pix(16'hFFFF, 8'd255, 8'd0, 1, 15, 0);
    wait_done("s5");
    check_pkt("s5", 8'hFF, 8'hFF);

    // 6: 3C C3 (checksum FF when enabled), then reset mid-payload
    clear_rx();
    fstart();
    send_pix(16'h3CC3, 8'd200, 8'd0, 0, 15, 0);
    wait_done("s6");
    check_pkt("s6", 8'h3C, 8'hC3);
    clear_rx();
    fstart();
    send_pix(16'h1234, 8'd200, 8'd0, 0, 15, 0);
    for (int i = 0; i < 1000 && start_q.size() < 3; i++) @(posedge clk);
    check_val("s6_payload_started", {31'd0, (start_q.size() >= 3)}, 32'd1);
    check_val("s6_tx_low", {31'd0, tx}, 32'd0);
    d0 = done_cnt;
    #2;
    reset = 1'b0;
    #1;
    check_val("s6_rst_tx", {31'd0, tx}, 32'd1);
    check_val("s6_rst_busy", {31'd0, busy}, 32'd0);
    idle(5);
    reset = 1'b1;
    idle(300);
    check_val("s6_no_done", done_cnt - d0, 32'd0);
    check_val("s6_idle_tx", {31'd0, tx}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/canny_frame_uart_tx.md
Name: canny_frame_uart_tx

Overview:
Parametrised successor of the Canny-to-UART transmit path. It binarises Canny pixels and packs 8 pixels per byte into an internal frame RAM. When a full frame is captured, it streams a framed packet (sync header, payload, optional checksum) over an internal 8N1 UART serializer. Sits between the Canny edge stage and the board TX pin; frame geometry, threshold and baud rate are parameters.

Parameters:
IMG_W, 170, pixels per line
IMG_H, 240, lines per frame; NPIX = IMG_W*IMG_H, must be a multiple of 8
NBYTES, derived, NPIX/8 (5100 at defaults); RAM depth and address width $clog2(NBYTES)
THRESH, 8'd128, pixel bit = 1 when canny_r >= THRESH
CLK_FREQ, 100_000_000, clk frequency in Hz
BAUD, 115200, UART bit rate; BIT_DIV = CLK_FREQ/BAUD clocks per bit, must be >= 2
HDR0, 8'hA5, first sync byte
HDR1, 8'h5A, second sync byte

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
frame_start  input  1  single-cycle pulse; clears packer and pixel counter (vsync)
canny_de  input  1  pixel valid qualifier
canny_r  input  8  Canny magnitude for the current pixel
tx  output  1  UART serial out, idle high
busy  output  1  high while a packet is being transmitted
frame_done  output  1  one-cycle pulse after last bit of packet's final stop bit
frame_drop  output  1  one-cycle pulse when a pixel arrives while busy

Behaviour:
- Reset values: tx=1, busy=0, frame_done=0, frame_drop=0, FSM=CAPTURE, pixel counter=0, shift register=0, baud/bit counters=0. RAM contents are not reset.
- CAPTURE: each cycle with canny_de=1, shift bit (canny_r>=THRESH) into the packer MSB-first: first pixel of a group lands in bit7.
- On the 8th pixel of a group, write the completed byte to RAM[pix_cnt>>3] in the same cycle the 8th pixel is accepted.
- When pixel NPIX is accepted: write the last byte, set busy=1 next cycle, enter HDR0.
- frame_start in CAPTURE: counter and packer clear. If canny_de is high in the same cycle, that pixel is pixel 0 of the new frame.
- frame_start while busy: ignored.
- canny_de while busy: pixel discarded and frame_drop pulses. Capture resumes only after the next frame_start following return to CAPTURE.
- TX FSM: HDR0 -> HDR1 -> PAYLOAD (addr 0..NBYTES-1) -> [CKSUM] -> DONE -> CAPTURE.
- Each state loads one byte into the serializer and advances only when the serializer reports idle.
- RAM read latency is 1 cycle. Issue the address one cycle before load; no bubble beyond that cycle is permitted between bytes.
- Serializer: start bit 0, 8 data bits LSB-first, stop bit 1. Each bit is held exactly BIT_DIV clocks, so one byte takes 10*BIT_DIV clocks. Back-to-back bytes follow with no idle gap beyond one clk.
- DONE: frame_done pulses once, busy falls in the same cycle, return to CAPTURE waiting for frame_start. Pixel counter is already 0.
- Reset mid-packet: tx returns to 1 immediately (asynchronous), packet abandoned, no frame_done.
- Counter widths: pixel counter $clog2(NPIX+1); baud counter $clog2(BIT_DIV); no wrap before terminal values.

Optional Feature:
Macro CANNY_TX_CKSUM_EN.
- Defined: after the last payload byte, send one extra byte equal to the XOR of all NBYTES payload bytes (headers excluded). The XOR is accumulated during PAYLOAD and cleared on entry to HDR0. Packet length is NBYTES+3.
- Undefined: CKSUM state and accumulator are absent; PAYLOAD goes directly to DONE; packet length is NBYTES+2.

Test Plan:
1. IMG_W=8, IMG_H=2, CLK_FREQ=400, BAUD=100 (BIT_DIV=4); frame_start, then 16 pixels canny_r = 200,0,200,0,... -> tx decodes A5 5A AA AA. frame_done pulses 4*40 clocks after tx first goes low (plus at most 3 load cycles).
2. Same config, canny_r = THRESH-1 then THRESH alternating -> payload 55 55. Threshold boundary checked exactly.
3. Same config, canny_de gaps (de high every 3rd cycle) -> identical bytes to scenario 1. busy rises only after 16th valid pixel.
4. During transmission drive 5 canny_de pulses -> frame_drop pulses 5 times. Next packet starts only after a fresh frame_start plus 16 pixels.
5. frame_start after 5 pixels, then 16 pixels all 255 -> payload FF FF. Partial frame fully discarded.
6. With CANNY_TX_CKSUM_EN, payload 3C C3 -> fifth byte FF. Deassert reset mid-payload -> tx=1 at once, busy=0, frame_done never pulses.
